// File: rtl/sram_fill_writer_if.sv
`default_nettype none
// sram_fill_writer_if -- burst command, write-word stream and SRAM port bundle.
// Revision 1.0
interface sram_fill_writer_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 72
);
   logic              i_startValid;
   logic [ADDR_W-1:0] i_startAddr;
   logic [ADDR_W:0]   i_len;
   logic              o_startReady;
   logic              i_dataValid;
   logic [DATA_W-1:0] i_data;
   logic              o_dataReady;
   logic              i_readReq;
   logic              o_readGrant;
   logic              o_readEn;
   logic              o_writeEn;
   logic [ADDR_W-1:0] o_writeAddr;
   logic [DATA_W-1:0] o_writeData;
   logic              o_busy;
   logic              o_done;

   modport slave (
      input  i_startValid, i_startAddr, i_len, i_dataValid, i_data, i_readReq,
      output o_startReady, o_dataReady, o_readGrant, o_readEn, o_writeEn,
             o_writeAddr, o_writeData, o_busy, o_done
   );

   modport master (
      output i_startValid, i_startAddr, i_len, i_dataValid, i_data, i_readReq,
      input  o_startReady, o_dataReady, o_readGrant, o_readEn, o_writeEn,
             o_writeAddr, o_writeData, o_busy, o_done
   );
endinterface
`default_nettype wire

// File: rtl/sram_fill_writer.sv
`default_nettype none
// sram_fill_writer -- burst write sequencer sharing one SRAM port with a read requester.
// Revision 1.0
module sram_fill_writer #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 72,
   parameter int STRIDE    = 1,
   parameter int MAX_STALL = 4
) (
   input logic               i_fire,
   input logic               rst,
   sram_fill_writer_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0]        STALL_LIMIT = 4'(MAX_STALL);
   localparam logic [ADDR_W-1:0] STEP        = ADDR_W'(STRIDE);
   localparam logic [ADDR_W:0]   ONE_BEAT    = (ADDR_W+1)'(1);

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;
   logic [3:0]        starve;

   logic              write_block;
   logic              grant;
   logic              start_ready;
   logic              data_ready;
   logic              accept;
   logic              busy;

   logic              read_en;
   logic              write_en;
   logic [ADDR_W-1:0] write_addr;
   logic [DATA_W-1:0] write_data;
   logic              done;

   always_comb begin
      state_next  = state;
      start_ready = 1'b0;
      data_ready  = 1'b0;
      grant       = bus.i_readReq;
      busy        = 1'b0;
      accept      = 1'b0;
      // Once a pending word has lost MAX_STALL times in a row, the write wins.
      write_block = bus.i_readReq && (starve < STALL_LIMIT);
      case (state)
         IDLE: begin
            start_ready = 1'b1;
            if (bus.i_startValid) begin
               state_next = (bus.i_len == '0) ? DONE : WRITE;
            end
         end
         WRITE: begin
            busy       = 1'b1;
            grant      = write_block;
            data_ready = !write_block;
            accept     = bus.i_dataValid && !write_block;
            if (accept && (remaining == ONE_BEAT)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_fire) begin
      if (rst) begin
         state      <= IDLE;
         addr       <= '0;
         remaining  <= '0;
         starve     <= '0;
         read_en    <= 1'b0;
         write_en   <= 1'b0;
         write_addr <= '0;
         write_data <= '0;
         done       <= 1'b0;
      end else begin
         state    <= state_next;
         read_en  <= grant;
         write_en <= accept;
         done     <= (state_next == DONE);
         if (accept) begin
            write_addr <= addr;
            write_data <= bus.i_data;
         end
         case (state)
            IDLE: begin
               if (bus.i_startValid && (bus.i_len != '0)) begin
                  addr      <= bus.i_startAddr;
                  remaining <= bus.i_len;
                  starve    <= '0;
               end
            end
            WRITE: begin
               if (accept) begin
                  addr      <= addr + STEP;
                  remaining <= remaining - ONE_BEAT;
                  starve    <= '0;
               end else if (bus.i_dataValid && write_block) begin
                  // write_block implies starve < limit, so this saturates at the limit.
                  starve <= starve + 4'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.o_startReady = start_ready;
   assign bus.o_dataReady  = data_ready;
   assign bus.o_readGrant  = grant;
   assign bus.o_readEn     = read_en;
   assign bus.o_writeEn    = write_en;
   assign bus.o_writeAddr  = write_addr;
   assign bus.o_writeData  = write_data;
   assign bus.o_busy       = busy;
   assign bus.o_done       = done;
endmodule
`default_nettype wire

// File: tb/tb_sram_fill_writer.sv
`default_nettype none
// tb_sram_fill_writer -- directed bursts with a write scoreboard and port-protocol monitor.
// Revision 1.0
module tb_sram_fill_writer;
   localparam int ADDR_W = 8;
   localparam int DATA_W = 72;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sram_fill_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   sram_fill_writer #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRIDE(1), .MAX_STALL(4)
   ) dut (
      .i_fire(clk),
      .rst   (rst),
      .bus   (bus)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              last;
   } wr_t;

   wr_t  exp_q[$];
   wr_t  mon_e;
   int   pass_cnt  = 0;
   int   total_cnt = 0;
   int   done_seen = 0;
   int   done_exp  = 0;
   logic prev_grant = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [DATA_W-1:0] mk(input logic [7:0] s, input logic [7:0] a);
      return {s, 56'h0123456789ABCD, a};
   endfunction

   // Monitor: pops the scoreboard on every SRAM write and checks port protocol.
   always @(negedge clk) begin
      if (bus.o_writeEn === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("write_addr", bus.o_writeAddr, mon_e.addr);
            check("write_data", bus.o_writeData, mon_e.data);
            check("done_with_last_write", bus.o_done, mon_e.last);
         end
      end
      if (bus.o_readEn || prev_grant)
         check("read_en_follows_grant", bus.o_readEn, prev_grant);
      if (bus.o_readEn || bus.o_writeEn)
         check("port_exclusive", bus.o_readEn && bus.o_writeEn, 0);
      if (bus.o_done === 1'b1) done_seen++;
      prev_grant = rst ? 1'b0 : bus.o_readGrant;
   end

   task automatic start(input logic [ADDR_W-1:0] a, input logic [ADDR_W:0] len);
      bus.i_startValid = 1'b1;
      bus.i_startAddr  = a;
      bus.i_len        = len;
      @(negedge clk);
      check("start_ready_idle", bus.o_startReady, 1);
      @(posedge clk); #1;
      bus.i_startValid = 1'b0;
   endtask

   task automatic send_word(input logic [DATA_W-1:0] d, input logic [ADDR_W-1:0] a,
                            input logic last, output int stalls);
      bit ok;
      ok     = 0;
      stalls = 0;
      bus.i_dataValid = 1'b1;
      bus.i_data      = d;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.o_dataReady) begin
            ok = 1;
            exp_q.push_back('{addr: a, data: d, last: last});
         end else begin
            stalls++;
         end
         @(posedge clk); #1;
      end
      if (!ok) check("data_accept_timeout", 0, 1);
   endtask

   task automatic finish_burst();
      bus.i_dataValid = 1'b0;
      bus.i_readReq   = 1'b0;
      done_exp++;
      @(negedge clk);
      check("busy_in_done", bus.o_busy, 1);
      @(posedge clk); #1;
      @(negedge clk);
      check("start_ready_after_done", bus.o_startReady, 1);
      check("busy_idle", bus.o_busy, 0);
      @(posedge clk); #1;
   endtask

   task automatic run_burst(input logic [7:0] seed, input logic [ADDR_W-1:0] a,
                            input logic [ADDR_W:0] len, input logic req, input int exp_stalls);
      int st;
      logic [ADDR_W-1:0] ad;
      ad = a;
      bus.i_readReq = req;
      start(a, len);
      for (int i = 0; i < int'(len); i++) begin
         send_word(mk(seed, ad), ad, (i == int'(len) - 1), st);
         check("stall_cycles", st, exp_stalls);
         ad = ad + 8'd1;
      end
      finish_burst();
   endtask

   initial begin
      int st;
      logic [ADDR_W-1:0] ad;
      bus.i_startValid = 1'b0;
      bus.i_startAddr  = '0;
      bus.i_len        = '0;
      bus.i_dataValid  = 1'b0;
      bus.i_data       = '0;
      bus.i_readReq    = 1'b0;

      // Reset state
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_write_en", bus.o_writeEn, 0);
      check("rst_read_en", bus.o_readEn, 0);
      check("rst_done", bus.o_done, 0);
      check("rst_busy", bus.o_busy, 0);
      check("rst_data_ready", bus.o_dataReady, 0);
      check("rst_write_addr", bus.o_writeAddr, 0);
      check("rst_write_data", bus.o_writeData, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // Basic burst: 0x10..0x13, back-to-back data, no reads
      run_burst(8'h01, 8'h10, 9'd4, 1'b0, 0);

      // Address wrap: 0xFE, 0xFF, 0x00
      run_burst(8'h02, 8'hFE, 9'd3, 1'b0, 0);

      // Starvation: read held high, each word waits exactly 4 cycles
      run_burst(8'h03, 8'h20, 9'd2, 1'b1, 4);

      // Zero-length burst
      start(8'h77, 9'd0);
      @(negedge clk);
      check("zlen_done", bus.o_done, 1);
      check("zlen_busy", bus.o_busy, 1);
      check("zlen_no_write", bus.o_writeEn, 0);
      done_exp++;
      @(posedge clk); #1;
      @(negedge clk);
      check("zlen_back_idle", bus.o_startReady, 1);
      @(posedge clk); #1;

      // Reset mid-burst after 3 of 8 beats
      ad = 8'h30;
      start(ad, 9'd8);
      for (int i = 0; i < 3; i++) begin
         send_word(mk(8'h04, ad), ad, 1'b0, st);
         ad = ad + 8'd1;
      end
      rst = 1'b1;
      bus.i_dataValid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_write_en", bus.o_writeEn, 0);
      check("midrst_read_en", bus.o_readEn, 0);
      check("midrst_done", bus.o_done, 0);
      check("midrst_busy", bus.o_busy, 0);
      check("midrst_write_addr", bus.o_writeAddr, 0);
      check("midrst_write_data", bus.o_writeData, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_burst(8'h05, 8'h40, 9'd1, 1'b0, 0);

      // Data bubbles: reads granted in the gaps
      ad = 8'h50;
      bus.i_readReq = 1'b0;
      start(ad, 9'd3);
      for (int i = 0; i < 3; i++) begin
         bus.i_readReq = 1'b0;
         send_word(mk(8'h06, ad), ad, (i == 2), st);
         check("bubble_stall", st, 0);
         ad = ad + 8'd1;
         if (i < 2) begin
            bus.i_dataValid = 1'b0;
            bus.i_readReq   = 1'b1;
            @(negedge clk);
            check("bubble_gap_grant", bus.o_readGrant, 1);
            @(posedge clk); #1;
         end
      end
      finish_burst();

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("scoreboard_empty", exp_q.size(), 0);
      check("done_pulse_count", done_seen, done_exp);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
`default_nettype wire
